vpm_pipe_ctrl: RTL

//  Stall/flush sequencer for a linear N-stage valid pipeline built from the VPM stage macros.
//  - Gathers per-stage hold requests, one multi-cycle operation slot and a pipeline flush request.
//  - Drives each stage register's load enable (stage_en) and active-low flush (flush_n, wired to hz_flush_n_<stage>).
//  - Stage 0 is the input stage (I); stage N-1 is the output stage (O).

---
 rtl/vpm_pipe_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/vpm_pipe_ctrl.sv
// Stall/flush sequencer for a linear valid pipeline: derives per-stage load enables
// and bubble-insert flushes from hold requests, one multi-cycle slot and a flush request.
module vpm_pipe_ctrl #(
  parameter int STAGES       = 5,
  parameter int MC_STAGE     = 2,
  parameter int CNT_W        = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [STAGES-1:0]           stage_valid,
  input  logic [STAGES-1:0]           hold_req,
  input  logic                        mc_start,
  input  logic [CNT_W-1:0]            mc_len,
  input  logic                        flush_req,
  input  logic [$clog2(STAGES)-1:0]   flush_from,
  output logic [STAGES-1:0]           stage_en,
  output logic [STAGES-1:0]           flush_n,
  output logic                        mc_busy,
  output logic                        mc_overlap,
  output logic [15:0]                 stall_cnt
);

  localparam int FH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [FH_W-1:0] FH_LOAD = FH_W'(FLUSH_CYCLES);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_MC = 2'd1, ST_FHOLD = 2'd2} state_e;

  state_e              state_r, state_nxt_s;
  logic [CNT_W-1:0]    mc_cnt_r, mc_cnt_nxt_s;
  logic [FH_W-1:0]     fh_cnt_r, fh_cnt_nxt_s;
  logic [15:0]         stall_cnt_r;
  int                  ff_idx_s;
  logic                mc_kill_s, mc_accept_s, mc_stall_s, mc_overlap_s, blocked_s;
  logic [STAGES-1:0]   active_s, en_s, fl_s;

  // Multi-cycle slot bookkeeping and clamped flush boundary
  always_comb begin
    ff_idx_s     = (int'(flush_from) > STAGES - 1) ? STAGES - 1 : int'(flush_from);
    mc_kill_s    = flush_req & (ff_idx_s >= MC_STAGE);
    mc_overlap_s = mc_start & (state_r == ST_MC);
    mc_accept_s  = mc_start & (mc_len != '0) & (state_r != ST_MC)
                   & (mc_cnt_r == '0) & ~mc_kill_s;
    mc_stall_s   = mc_accept_s | (mc_cnt_r != '0);
  end

  // Enables and bubbles: everything at or below the highest stalled stage freezes
  always_comb begin
    active_s  = stage_valid & hold_req;
    en_s      = '0;
    fl_s      = '1;
    blocked_s = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (k == MC_STAGE) begin
        active_s[k] = active_s[k] | mc_stall_s;
      end else begin
        active_s[k] = active_s[k];
      end
      blocked_s = blocked_s | active_s[k];
      en_s[k]   = ~blocked_s;
    end
    // The first enabled stage above a frozen one would otherwise duplicate its entry
    for (int k = 1; k < STAGES; k++) begin
      fl_s[k] = ~(en_s[k] & ~en_s[k-1]);
    end
    if (flush_req) begin
      en_s = '1;
      for (int k = 0; k < STAGES; k++) begin
        fl_s[k] = (k > ff_idx_s);
      end
    end else if (state_r == ST_FHOLD) begin
      en_s[0] = 1'b0;
      fl_s[0] = 1'b0;
    end else begin
      fl_s[0] = 1'b1;
    end
  end

  // Next-state logic: flush dominates, MC counter keeps running through FHOLD
  always_comb begin
    if (mc_kill_s) begin
      mc_cnt_nxt_s = '0;
    end else if (mc_accept_s) begin
      mc_cnt_nxt_s = mc_len - CNT_W'(1);
    end else if (mc_cnt_r != '0) begin
      mc_cnt_nxt_s = mc_cnt_r - CNT_W'(1);
    end else begin
      mc_cnt_nxt_s = mc_cnt_r;
    end

    state_nxt_s  = ST_RUN;
    fh_cnt_nxt_s = '0;
    case (state_r)
      ST_RUN, ST_MC, ST_FHOLD: begin
        if (flush_req && (FLUSH_CYCLES > 0)) begin
          state_nxt_s  = ST_FHOLD;
          fh_cnt_nxt_s = FH_LOAD;
        end else if ((state_r == ST_FHOLD) && (fh_cnt_r > FH_W'(1))) begin
          state_nxt_s  = ST_FHOLD;
          fh_cnt_nxt_s = fh_cnt_r - FH_W'(1);
        end else begin
          state_nxt_s  = (mc_cnt_nxt_s != '0) ? ST_MC : ST_RUN;
          fh_cnt_nxt_s = '0;
        end
      end
      default: begin
        state_nxt_s  = ST_RUN;
        fh_cnt_nxt_s = '0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_RUN;
      mc_cnt_r <= '0;
      fh_cnt_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      mc_cnt_r <= mc_cnt_nxt_s;
      fh_cnt_r <= fh_cnt_nxt_s;
    end
  end

  // Saturating count of cycles the output stage did not load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'h0000;
    end else if (!en_s[STAGES-1] && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Zero-latency outputs, forced quiet while reset is asserted
  assign stage_en   = rst_n ? en_s : '0;
  assign flush_n    = rst_n ? fl_s : '0;
  assign mc_busy    = rst_n & (state_r == ST_MC);
  assign mc_overlap = rst_n & mc_overlap_s;
  assign stall_cnt  = stall_cnt_r;

endmodule
